break_arb: RTL

Parametrised data-break (DMA) arbiter between NCH peripheral channels (RK8E disk, future DF32/TC08-style controllers) and the CPU state machine's single break port. It selects one requesting channel, drives the shared break address, direction and write data toward the state machine and memory-address path, tracks the break cycle, and returns read data plus a completion strobe to the granted channel. It generalises today's single hard-wired disk break connection to N channels with selectable fixed or round-robin priority and bounded bursts.

---
 rtl/break_arb.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/break_arb.sv
// break_arb: data-break (DMA) arbiter between NCH peripheral channels and the
// CPU state machine's single break port. It picks one requester, with fixed or
// round-robin priority, and presents that channel's address, data and direction
// on the break port. Once the state machine finishes the cycle, it returns the
// read data and a one-cycle ack to the owner. Bursts are bounded by BURST.
module break_arb #(
  parameter int NCH   = 2,
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int RR    = 0,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_to_mem,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_ack,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    grant,
  output logic              data_break,
  output logic              to_mem,
  output logic [AW-1:0]     dma_addr,
  output logic [DW-1:0]     dma_wdata,
  input  logic              break_in_prog,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BRK  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t         r_state;
  logic [NCH-1:0] r_grant;
  logic [NCH-1:0] r_ack;
  logic [DW-1:0]  r_rdata;
  logic           r_break;
  logic           r_to_mem;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [3:0]     r_burst;
  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  r_own;

  logic           w_found;
  logic [IW-1:0]  w_win;
  int             w_idx;
  logic [AW-1:0]  w_win_addr;
  logic [DW-1:0]  w_win_wdata;
  logic [AW-1:0]  w_own_addr;
  logic [DW-1:0]  w_own_wdata;
  logic [3:0]     w_burst_inc;
  logic           w_burst_more;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
    logic [NCH-1:0] oh;
    oh = '0;
    for (int i = 0; i < NCH; i++) begin
      oh[i] = (IW'(i) == idx);
    end
    return oh;
  endfunction

  // Winner search: lowest index, or starting one past the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      if (RR != 0) begin
        w_idx = int'(r_ptr) + 1 + k;
        if (w_idx >= NCH) begin
          w_idx = w_idx - NCH;
        end else begin
          w_idx = w_idx;
        end
      end else begin
        w_idx = k;
      end
      if (!w_found && ch_req[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_win_addr   = ch_addr[w_win*AW +: AW];
  assign w_win_wdata  = ch_wdata[w_win*DW +: DW];
  assign w_own_addr   = ch_addr[r_own*AW +: AW];
  assign w_own_wdata  = ch_wdata[r_own*DW +: DW];
  assign w_burst_inc  = r_burst + 4'd1;
  assign w_burst_more = (w_burst_inc < 4'(BURST));

  // Break sequencer: arbitration, break handshake, ack and burst accounting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_ack    <= '0;
      r_rdata  <= '0;
      r_break  <= 1'b0;
      r_to_mem <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_burst  <= 4'd0;
      r_ptr    <= IW'(NCH - 1);
      r_own    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= '0;
          if (w_found) begin
            r_state  <= S_REQ;
            r_own    <= w_win;
            r_grant  <= onehot(w_win);
            r_break  <= 1'b1;
            r_to_mem <= ch_to_mem[w_win];
            r_addr   <= w_win_addr;
            r_wdata  <= w_win_wdata;
            r_burst  <= 4'd0;
          end else begin
            r_grant  <= '0;
            r_break  <= 1'b0;
            r_to_mem <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
          end
        end
        S_REQ: begin
          if (break_in_prog) begin
            r_state <= S_BRK;
          end else if (!ch_req[r_own]) begin
            // Owner withdrew before the cycle started: drop without ack.
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_break  <= 1'b0;
            r_to_mem <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_BRK: begin
          if (!break_in_prog) begin
            r_state <= S_ACK;
            r_rdata <= mem_rdata;
            r_ack   <= r_grant;
            r_break <= 1'b0;
          end else begin
            r_state <= S_BRK;
          end
        end
        S_ACK: begin
          r_ack <= '0;
          if (ch_req[r_own] && w_burst_more) begin
            // Burst continuation: same owner, fresh address/data, no arbitration.
            r_state  <= S_REQ;
            r_break  <= 1'b1;
            r_burst  <= w_burst_inc;
            r_to_mem <= ch_to_mem[r_own];
            r_addr   <= w_own_addr;
            r_wdata  <= w_own_wdata;
          end else begin
            r_state  <= S_IDLE;
            r_burst  <= 4'd0;
            r_grant  <= '0;
            r_ptr    <= r_own;
            r_to_mem <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= '0;
          r_break <= 1'b0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign ch_ack     = r_ack;
  assign ch_rdata   = r_rdata;
  assign grant      = r_grant;
  assign data_break = r_break;
  assign to_mem     = r_to_mem;
  assign dma_addr   = r_addr;
  assign dma_wdata  = r_wdata;

endmodule
